cursor_ctrl: RTL and testbench



---
 rtl/cursor_pkg.sv | 61 ++++++
 rtl/sat_acc.sv | 61 ++++++
 rtl/cursor_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_cursor_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_pkg.sv
// ----------------------------------------------------------------------------
// cursor_pkg
// Shared definitions for the cursor controller slice.
//
// Contents:
//   - Default screen and cursor geometry (used as parameter defaults).
//   - Datapath widths for positions, deltas, accumulators and the
//     signed arithmetic used when applying motion.
//   - Field positions of the cursor's sprite-table word.
//   - cursor_state_t, the frame-commit FSM state type.
//   - pack_table(), which assembles a sprite-table word from id/x/y.
// ----------------------------------------------------------------------------
package cursor_pkg;

   // Default geometry. The controller exposes these as overridable parameters.
   localparam int SCREEN_W_DEF = 640;
   localparam int SCREEN_H_DEF = 480;
   localparam int CURSOR_W_DEF = 11;
   localparam int CURSOR_H_DEF = 11;
   localparam int ACC_MAX_DEF  = 255;
   localparam logic [5:0] CURSOR_ID_DEF = 6'd1;

   // Datapath widths.
   localparam int POS_W   = 10;
   localparam int DELTA_W = 9;
   localparam int ACC_W   = 10;
   localparam int CALC_W  = 12;
   localparam int ID_W    = 6;

   // Motion above this magnitude is doubled when acceleration is enabled.
   localparam int ACCEL_THRESH = 32;

   // Sprite-table word field slices.
   localparam int ID_HI = 31;
   localparam int ID_LO = 26;
   localparam int X_HI  = 23;
   localparam int X_LO  = 14;
   localparam int Y_HI  = 13;
   localparam int Y_LO  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      COMMIT = 2'd2
   } cursor_state_t;

   // Bits [25:24] and [3:0] of the word are reserved and always zero.
   function automatic logic [31:0] pack_table(
      input logic [ID_W-1:0]  id,
      input logic [POS_W-1:0] x,
      input logic [POS_W-1:0] y
   );
      logic [31:0] word;
      word              = '0;
      word[ID_HI:ID_LO] = id;
      word[X_HI:X_LO]   = x;
      word[Y_HI:Y_LO]   = y;
      return word;
   endfunction

endpackage

// File: rtl/sat_acc.sv
// ----------------------------------------------------------------------------
// sat_acc
// Signed saturating accumulator for pending cursor motion on one axis.
// Each accepted delta is added to the running total, and the total is held
// within [-ACC_MAX, +ACC_MAX] so a burst of fast motion cannot wrap around.
//
// Ports:
//   clk     in   clock
//   reset   in   synchronous active-high reset, clears the total
//   clear   in   discard the total (used once the motion has been applied)
//   add_en  in   add delta this cycle
//   delta   in   signed motion delta
//   acc     out  signed saturated running total
// ----------------------------------------------------------------------------
module sat_acc #(
   parameter int ACC_MAX = 255,
   parameter int DELTA_W = 9,
   parameter int ACC_W   = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      add_en,
   input  logic signed [DELTA_W-1:0] delta,
   output logic signed [ACC_W-1:0]   acc
);

   // One extra bit so the raw sum of two in-range values never overflows.
   localparam int SUM_W = ACC_W + 1;
   localparam logic signed [SUM_W-1:0] POS_LIMIT = SUM_W'(ACC_MAX);
   localparam logic signed [SUM_W-1:0] NEG_LIMIT = -SUM_W'(ACC_MAX);

   logic signed [SUM_W-1:0] sum;
   logic signed [ACC_W-1:0] acc_next;

   // Sign-extend both operands, add, then pin the result to the limits.
   always_comb begin
      sum = {acc[ACC_W-1], acc}
          + {{(SUM_W-DELTA_W){delta[DELTA_W-1]}}, delta};
      if (sum > POS_LIMIT) begin
         acc_next = ACC_W'(POS_LIMIT);
      end else if (sum < NEG_LIMIT) begin
         acc_next = ACC_W'(NEG_LIMIT);
      end else begin
         acc_next = ACC_W'(sum);
      end
   end

   // Clearing wins over adding; the controller never requests both at once
   // because requests are only accepted while the FSM is idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (add_en) begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/cursor_ctrl.sv
// ----------------------------------------------------------------------------
// cursor_ctrl
// Owns the cursor sprite's sprite-table word. Motion requests from the input
// decoders are accumulated between frames, applied and clamped to the screen
// at the frame-sync pulse, and committed once per frame so the cursor never
// tears mid-frame.
//
// Optional feature: define CURSOR_ACCEL_EN to double any pending motion whose
// magnitude exceeds 32 before it is applied. Undefined, motion is 1:1.
//
// Ports:
//   Clk         in   system clock
//   Reset       in   synchronous active-high reset
//   frame_sync  in   one-cycle pulse at the start of vertical blank
//   move_valid  in   motion request present
//   move_ready  out  request accepted this cycle (only while idle)
//   move_dx     in   signed X delta
//   move_dy     in   signed Y delta
//   hide        in   1 forces the sprite id to 0 at the next commit
//   btn         in   raw button level
//   table_val   out  sprite-table word {id, 2'b0, x, y, 4'b0}
//   cursor_x    out  committed right-edge X
//   cursor_y    out  committed top Y
//   click       out  one-cycle pulse on a committed button press
//   busy        out  high while applying or committing a frame
// ----------------------------------------------------------------------------
module cursor_ctrl
   import cursor_pkg::*;
#(
   parameter int         SCREEN_W  = SCREEN_W_DEF,
   parameter int         SCREEN_H  = SCREEN_H_DEF,
   parameter int         CURSOR_W  = CURSOR_W_DEF,
   parameter int         CURSOR_H  = CURSOR_H_DEF,
   parameter int         ACC_MAX   = ACC_MAX_DEF,
   parameter logic [5:0] CURSOR_ID = CURSOR_ID_DEF
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      frame_sync,
   input  logic                      move_valid,
   output logic                      move_ready,
   input  logic signed [DELTA_W-1:0] move_dx,
   input  logic signed [DELTA_W-1:0] move_dy,
   input  logic                      hide,
   input  logic                      btn,
   output logic [31:0]               table_val,
   output logic [POS_W-1:0]          cursor_x,
   output logic [POS_W-1:0]          cursor_y,
   output logic                      click,
   output logic                      busy
);

   // The cursor's X is its right edge, so the sprite stays fully on screen
   // when X lies in [CURSOR_W, SCREEN_W]; Y is its top edge.
   localparam logic signed [CALC_W-1:0] X_MIN = CALC_W'(CURSOR_W);
   localparam logic signed [CALC_W-1:0] X_MAX = CALC_W'(SCREEN_W);
   localparam logic signed [CALC_W-1:0] Y_MIN = '0;
   localparam logic signed [CALC_W-1:0] Y_MAX = CALC_W'(SCREEN_H - CURSOR_H);
   localparam logic [POS_W-1:0] X_HOME = POS_W'(SCREEN_W / 2);
   localparam logic [POS_W-1:0] Y_HOME = POS_W'(SCREEN_H / 2);

   cursor_state_t state, state_next;

   logic                    apply_en;
   logic                    commit_en;
   logic                    transfer;
   logic signed [ACC_W-1:0] acc_x;
   logic signed [ACC_W-1:0] acc_y;

   logic signed [CALC_W-1:0] eff_x, eff_y;
   logic signed [CALC_W-1:0] sum_x, sum_y;
   logic signed [CALC_W-1:0] clamp_x, clamp_y;

   logic [POS_W-1:0] nx_r, ny_r;
   logic             btn_now;
   logic             btn_prev;

   function automatic logic signed [CALC_W-1:0] clamp_range(
      input logic signed [CALC_W-1:0] v,
      input logic signed [CALC_W-1:0] lo,
      input logic signed [CALC_W-1:0] hi
   );
      if (v < lo) begin
         return lo;
      end else if (v > hi) begin
         return hi;
      end
      return v;
   endfunction

   // State register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: a frame walks IDLE -> APPLY -> COMMIT -> IDLE, and
   // frame_sync pulses seen outside IDLE are simply dropped.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (frame_sync) state_next = APPLY;
         APPLY:   state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode. Requests are only taken while idle, which guarantees the
   // accumulators are stable for the whole APPLY/COMMIT sequence.
   always_comb begin
      move_ready = 1'b0;
      busy       = 1'b1;
      apply_en   = 1'b0;
      commit_en  = 1'b0;
      case (state)
         IDLE: begin
            move_ready = 1'b1;
            busy       = 1'b0;
         end
         APPLY:   apply_en  = 1'b1;
         COMMIT:  commit_en = 1'b1;
         default: busy      = 1'b0;
      endcase
   end

   assign transfer = move_valid & move_ready;

   // A transfer in the same cycle as frame_sync lands in the accumulator on
   // the IDLE->APPLY edge, so APPLY already sees it and it joins this frame.
   sat_acc #(
      .ACC_MAX (ACC_MAX),
      .DELTA_W (DELTA_W),
      .ACC_W   (ACC_W)
   ) u_acc_x (
      .clk    (Clk),
      .reset  (Reset),
      .clear  (apply_en),
      .add_en (transfer),
      .delta  (move_dx),
      .acc    (acc_x)
   );

   sat_acc #(
      .ACC_MAX (ACC_MAX),
      .DELTA_W (DELTA_W),
      .ACC_W   (ACC_W)
   ) u_acc_y (
      .clk    (Clk),
      .reset  (Reset),
      .clear  (apply_en),
      .add_en (transfer),
      .delta  (move_dy),
      .acc    (acc_y)
   );

   // New position in 12-bit signed arithmetic. With acceleration the pending
   // motion can reach twice ACC_MAX, which still fits comfortably.
   always_comb begin
      eff_x = CALC_W'(acc_x);
      eff_y = CALC_W'(acc_y);
`ifdef CURSOR_ACCEL_EN
      if (eff_x > CALC_W'(ACCEL_THRESH) || eff_x < -CALC_W'(ACCEL_THRESH)) begin
         eff_x = eff_x <<< 1;
      end
      if (eff_y > CALC_W'(ACCEL_THRESH) || eff_y < -CALC_W'(ACCEL_THRESH)) begin
         eff_y = eff_y <<< 1;
      end
`else
`endif
      sum_x   = $signed({2'b00, cursor_x}) + eff_x;
      sum_y   = $signed({2'b00, cursor_y}) + eff_y;
      clamp_x = clamp_range(sum_x, X_MIN, X_MAX);
      clamp_y = clamp_range(sum_y, Y_MIN, Y_MAX);
   end

   // APPLY captures the clamped position and the button level; COMMIT then
   // publishes them together so the ROM sees one consistent word per frame.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         nx_r      <= X_HOME;
         ny_r      <= Y_HOME;
         btn_now   <= 1'b0;
         btn_prev  <= 1'b0;
         cursor_x  <= X_HOME;
         cursor_y  <= Y_HOME;
         table_val <= pack_table(CURSOR_ID, X_HOME, Y_HOME);
         click     <= 1'b0;
      end else begin
         click <= 1'b0;
         if (apply_en) begin
            nx_r    <= POS_W'(clamp_x);
            ny_r    <= POS_W'(clamp_y);
            btn_now <= btn;
         end
         if (commit_en) begin
            cursor_x  <= nx_r;
            cursor_y  <= ny_r;
            table_val <= pack_table(hide ? 6'd0 : CURSOR_ID, nx_r, ny_r);
            click     <= btn_now & ~btn_prev;
            btn_prev  <= btn_now;
         end
      end
   end

endmodule

// File: tb/tb_cursor_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cursor_ctrl
// Self-checking bench for cursor_ctrl. A frame-level model predicts every
// output each cycle; directed sequences with literal expectations pin the
// model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_cursor_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_sync;
   logic        move_valid;
   logic        move_ready;
   logic [8:0]  move_dx;
   logic [8:0]  move_dy;
   logic        hide;
   logic        btn;
   logic [31:0] table_val;
   logic [9:0]  cursor_x;
   logic [9:0]  cursor_y;
   logic        click;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 Clk = ~Clk;

   cursor_ctrl dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_sync (frame_sync),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .move_dx    (move_dx),
      .move_dy    (move_dy),
      .hide       (hide),
      .btn        (btn),
      .table_val  (table_val),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y),
      .click      (click),
      .busy       (busy)
   );

   // Frame-level model: plain integers for position and pending motion, and
   // a count of busy cycles left in the current frame update.
   int m_x, m_y, m_acc_x, m_acc_y, m_tx, m_ty;
   int m_busy_left, m_id, m_click, m_btn_cap, m_btn_prev;
   bit m_live = 1'b0;

   function automatic int sat_m(input int v);
      if (v > 255) return 255;
      if (v < -255) return -255;
      return v;
   endfunction

   function automatic int clamp_m(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic int boost_m(input int a);
`ifdef CURSOR_ACCEL_EN
      if (a > 32 || a < -32) return 2 * a;
`endif
      return a;
   endfunction

   always @(posedge Clk) begin
      if (Reset) begin
         m_x = 320; m_y = 240; m_acc_x = 0; m_acc_y = 0;
         m_busy_left = 0; m_id = 1; m_click = 0;
         m_btn_cap = 0; m_btn_prev = 0;
         m_live = 1'b1;
      end else if (m_live) begin
         m_click = 0;
         if (m_busy_left == 2) begin
            m_tx = clamp_m(m_x + boost_m(m_acc_x), 11, 640);
            m_ty = clamp_m(m_y + boost_m(m_acc_y), 0, 469);
            m_acc_x = 0;
            m_acc_y = 0;
            m_btn_cap = int'(btn);
            m_busy_left = 1;
         end else if (m_busy_left == 1) begin
            m_x = m_tx;
            m_y = m_ty;
            m_id = hide ? 0 : 1;
            m_click = (m_btn_cap == 1 && m_btn_prev == 0) ? 1 : 0;
            m_btn_prev = m_btn_cap;
            m_busy_left = 0;
         end else begin
            if (move_valid) begin
               m_acc_x = sat_m(m_acc_x + int'($signed(move_dx)));
               m_acc_y = sat_m(m_acc_y + int'($signed(move_dy)));
            end
            if (frame_sync) m_busy_left = 2;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge Clk) begin
      if (m_live) begin
         checkOutput("ready", 32'(move_ready), 32'(m_busy_left == 0));
         checkOutput("busy", 32'(busy), 32'(m_busy_left != 0));
         checkOutput("x", 32'(cursor_x), 32'(m_x));
         checkOutput("y", 32'(cursor_y), 32'(m_y));
         checkOutput("click", 32'(click), 32'(m_click));
         checkOutput("table", table_val,
                     (32'(m_id) << 26) | (32'(m_x) << 14) | (32'(m_y) << 4));
      end
   end

   // Holds the given inputs across exactly one rising edge.
   task automatic applyStimulus(input bit fs, input bit v, input int dx, input int dy);
      frame_sync = fs;
      move_valid = v;
      move_dx    = 9'(dx);
      move_dy    = 9'(dy);
      @(negedge Clk);
   endtask

   task automatic doFrame();
      applyStimulus(1'b1, 1'b0, 0, 0);
      applyStimulus(1'b0, 1'b0, 0, 0);
      applyStimulus(1'b0, 1'b0, 0, 0);
   endtask

   task automatic doReset();
      Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 0, 0);
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; frame_sync = 1'b0; move_valid = 1'b0;
      move_dx = '0; move_dy = '0; hide = 1'b0; btn = 1'b0;

      // Reset state
      applyStimulus(1'b0, 1'b0, 0, 0);
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("lit_rst_table", table_val, 32'h0450_0F00);
      checkOutput("lit_rst_x", 32'(cursor_x), 32'd320);
      checkOutput("lit_rst_y", 32'(cursor_y), 32'd240);
      checkOutput("lit_rst_ready", 32'(move_ready), 32'd1);
      Reset = 1'b0;

      // Basic move with busy window
      applyStimulus(1'b0, 1'b1, 5, -3);
      applyStimulus(1'b1, 1'b0, 0, 0);
      checkOutput("lit_busy_c1", 32'(busy), 32'd1);
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("lit_busy_c2", 32'(busy), 32'd1);
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("lit_busy_c3", 32'(busy), 32'd0);
      checkOutput("lit_basic_x", 32'(cursor_x), 32'd325);
      checkOutput("lit_basic_y", 32'(cursor_y), 32'd237);

      // Clamping on all three limits
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 255, 0);
         doFrame();
      end
      checkOutput("lit_clamp_xmax", 32'(cursor_x), 32'd640);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, -255, 0);
         doFrame();
      end
      checkOutput("lit_clamp_xmin", 32'(cursor_x), 32'd11);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b1, 0, 255);
         doFrame();
      end
      checkOutput("lit_clamp_ymax", 32'(cursor_y), 32'd469);

      // Accumulator saturation and back-pressure while busy
      doReset();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 100, 0);
      applyStimulus(1'b1, 1'b1, 100, 0);
      checkOutput("lit_ready_apply", 32'(move_ready), 32'd0);
      applyStimulus(1'b0, 1'b1, 7, 0);
      checkOutput("lit_ready_commit", 32'(move_ready), 32'd0);
      applyStimulus(1'b0, 1'b1, 7, 0);
      checkOutput("lit_ready_idle", 32'(move_ready), 32'd1);
`ifdef CURSOR_ACCEL_EN
      checkOutput("lit_sat_x", 32'(cursor_x), 32'd640);
`else
      checkOutput("lit_sat_x", 32'(cursor_x), 32'd575);
`endif
      applyStimulus(1'b0, 1'b1, 7, 0);
      doFrame();
`ifdef CURSOR_ACCEL_EN
      checkOutput("lit_held_req_x", 32'(cursor_x), 32'd640);
`else
      checkOutput("lit_held_req_x", 32'(cursor_x), 32'd582);
`endif

      // Transfer coinciding with frame_sync
      doReset();
      applyStimulus(1'b1, 1'b1, 3, 2);
      applyStimulus(1'b0, 1'b0, 0, 0);
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("lit_coinc_x", 32'(cursor_x), 32'd323);
      checkOutput("lit_coinc_y", 32'(cursor_y), 32'd242);

      // Second frame_sync during APPLY is ignored
      applyStimulus(1'b0, 1'b1, 10, 0);
      applyStimulus(1'b1, 1'b0, 0, 0);
      applyStimulus(1'b1, 1'b0, 0, 0);
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("lit_dbl_fs_x", 32'(cursor_x), 32'd333);
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("lit_dbl_fs_busy", 32'(busy), 32'd0);

      // Reset during COMMIT
      applyStimulus(1'b0, 1'b1, 20, 0);
      applyStimulus(1'b1, 1'b0, 0, 0);
      applyStimulus(1'b0, 1'b0, 0, 0);
      Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 0, 0);
      Reset = 1'b0;
      checkOutput("lit_rst_commit_x", 32'(cursor_x), 32'd320);
      checkOutput("lit_rst_commit_table", table_val, 32'h0450_0F00);
      checkOutput("lit_rst_commit_busy", 32'(busy), 32'd0);
      doFrame();
      checkOutput("lit_rst_discard_x", 32'(cursor_x), 32'd320);

      // Hide and unhide
      hide = 1'b1;
      doFrame();
      checkOutput("lit_hide_table", table_val, 32'h0050_0F00);
      hide = 1'b0;
      doFrame();
      checkOutput("lit_unhide_table", table_val, 32'h0450_0F00);

      // Click on a button press between frames
      btn = 1'b1;
      applyStimulus(1'b0, 1'b0, 0, 0);
      doFrame();
      checkOutput("lit_click_hi", 32'(click), 32'd1);
      applyStimulus(1'b0, 1'b0, 0, 0);
      checkOutput("lit_click_lo", 32'(click), 32'd0);
      doFrame();
      checkOutput("lit_click_once", 32'(click), 32'd0);
      btn = 1'b0;

      // Acceleration threshold
      doReset();
      applyStimulus(1'b0, 1'b1, 40, 0);
      doFrame();
`ifdef CURSOR_ACCEL_EN
      checkOutput("lit_accel_x", 32'(cursor_x), 32'd400);
`else
      checkOutput("lit_accel_x", 32'(cursor_x), 32'd360);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
